// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: diff = a - b - bin, one 4-bit borrow-lookahead slice per clock.
// Optional zero/ovf flag outputs are built when SUB_FLAGS_EN is defined.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [KW-1:0]    k;
  logic             borrow;
  logic [3:0]       x_s;
  logic [3:0]       y_s;
  logic [5:0]       slice_res;
  logic [WIDTH-1:0] diff_nxt;
  logic             last_slice;
  logic             accept;
  logic             consume;

  // Returns {c4, c3, diff[3:0]} for one nibble of x - y - c0.
  function automatic logic [5:0] slice_sub(input logic [3:0] x, input logic [3:0] y,
                                           input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = ~x & y;
    p    = ~(x ^ y);
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], c[3], x ^ y ^ c[3:0]};
  endfunction

  always_comb begin
    x_s        = a_r[int'(k)*4 +: 4];
    y_s        = b_r[int'(k)*4 +: 4];
    slice_res  = slice_sub(x_s, y_s, borrow);
    diff_nxt   = diff;
    diff_nxt[int'(k)*4 +: 4] = slice_res[3:0];
    last_slice = (k == KW'(N - 1));
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    consume   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          consume   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operands are pure data: captured only at acceptance, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      k      <= '0;
      borrow <= bin;
    end else if (state == RUN) begin
      diff   <= diff_nxt;
      borrow <= slice_res[5];
      if (last_slice) bout <= slice_res[5];
      else            k    <= k + KW'(1);
    end
  end

`ifdef SUB_FLAGS_EN
  // Flags latch with bout on the final slice; ovf is carry into MSB xor borrow out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == RUN && last_slice) begin
      zero <= (diff_nxt == '0);
      ovf  <= slice_res[5] ^ slice_res[4];
    end
  end
`endif

  logic unused_consume;
  assign unused_consume = consume;

endmodule
